// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states,
// default data width.
package rf_seq_pkg;

    localparam int DATA_W_DEF = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MOV = 3'b101,
        OP_LDI = 3'b110,
        OP_NOP = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // Every opcode except NOP writes its result back to the register file.
    function automatic logic op_writes(input logic [2:0] op);
        return op != OP_NOP;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Four-entry register file: combinational reads, write on rising edge.
// No reset, so stored values survive a sequencer reset.
module reg_file #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic [1:0]        SEL_A,
    input  logic [1:0]        SEL_B,
    input  logic [1:0]        SEL_W,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              write_en,
    output logic [DATA_W-1:0] OUT_A,
    output logic [DATA_W-1:0] OUT_B
);

    logic [DATA_W-1:0] mem [4];

    // Single write port.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[SEL_W] <= DATA_IN;
        end
    end

    assign OUT_A = mem[SEL_A];
    assign OUT_B = mem[SEL_B];

endmodule

// File: rtl/rf_sequencer_alu4.sv
// Combinational ALU used by the sequencer's EXEC step.
module alu4
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        OP,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] IMM,
    output logic [DATA_W-1:0] result,
    output logic              C,
    output logic              Z
);

    logic [DATA_W:0] sum_ext;

    assign sum_ext = {1'b0, A} + {1'b0, B};

    // Result and carry per opcode; only ADD and SUB produce a carry.
    always_comb begin
        result = '0;
        C      = 1'b0;
        case (OP)
            OP_ADD: begin
                result = sum_ext[DATA_W-1:0];
                C      = sum_ext[DATA_W];
            end
            OP_SUB: begin
                result = A - B;
                C      = (A >= B);
            end
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            OP_MOV:  result = A;
            OP_LDI:  result = IMM;
            default: result = '0;
        endcase
        Z = (result == '0);
    end

endmodule

// File: rtl/rf_sequencer.sv
// Four-step instruction sequencer around an external register file:
// IDLE (accept) -> READ (fetch operands) -> EXEC (ALU) -> WB (write back),
// followed by a one-cycle done pulse back in IDLE.
module rf_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        OP,
    input  logic [1:0]        RD,
    input  logic [1:0]        RS1,
    input  logic [1:0]        RS2,
    input  logic [DATA_W-1:0] IMM,
    output logic [1:0]        SEL_A,
    output logic [1:0]        SEL_B,
    input  logic [DATA_W-1:0] OUT_A,
    input  logic [DATA_W-1:0] OUT_B,
    output logic [1:0]        SEL_W,
    output logic [DATA_W-1:0] DATA_IN,
    output logic              write_en,
    output logic              done,
    output logic [DATA_W-1:0] RESULT,
    output logic              C,
    output logic              Z
);

    state_t state_reg, state_next;

    logic [2:0]        op_reg;
    logic [1:0]        rd_reg, rs1_reg, rs2_reg;
    logic [DATA_W-1:0] imm_reg;
    logic [DATA_W-1:0] a_reg, b_reg;
    logic [DATA_W-1:0] res_reg;
    logic              c_reg, z_reg;
    logic [DATA_W-1:0] result_reg;
    logic              c_out_reg, z_out_reg, done_reg;

    logic              load_instr, load_ops, load_res, finish;
    logic [DATA_W-1:0] alu_result;
    logic              alu_c, alu_z;

    alu4 #(.DATA_W(DATA_W)) u_alu (
        .OP     (op_reg),
        .A      (a_reg),
        .B      (b_reg),
        .IMM    (imm_reg),
        .result (alu_result),
        .C      (alu_c),
        .Z      (alu_z)
    );

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic and per-state strobes. write_en is decoded from the
    // state so an asynchronous reset drops it at once.
    always_comb begin
        state_next  = state_reg;
        instr_ready = 1'b0;
        write_en    = 1'b0;
        load_instr  = 1'b0;
        load_ops    = 1'b0;
        load_res    = 1'b0;
        finish      = 1'b0;
        case (state_reg)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    load_instr = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                load_ops   = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                load_res   = 1'b1;
                state_next = WB;
            end
            WB: begin
                write_en   = op_writes(op_reg);
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Instruction fields are captured only on acceptance, so inputs seen while
    // busy never disturb an instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg  <= 3'd0;
            rd_reg  <= 2'd0;
            rs1_reg <= 2'd0;
            rs2_reg <= 2'd0;
            imm_reg <= '0;
        end else if (load_instr) begin
            op_reg  <= OP;
            rd_reg  <= RD;
            rs1_reg <= RS1;
            rs2_reg <= RS2;
            imm_reg <= IMM;
        end
    end

    // Operand capture in READ; this precedes WB, so RD may alias RS1/RS2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (load_ops) begin
            a_reg <= OUT_A;
            b_reg <= OUT_B;
        end
    end

    // ALU result and flags registered in EXEC; res_reg feeds write-back data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_reg <= '0;
            c_reg   <= 1'b0;
            z_reg   <= 1'b0;
        end else if (load_res) begin
            res_reg <= alu_result;
            c_reg   <= alu_c;
            z_reg   <= alu_z;
        end
    end

    // Visible result/flags update together with the done pulse and hold
    // until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            c_out_reg  <= 1'b0;
            z_out_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= finish;
            if (finish) begin
                result_reg <= res_reg;
                c_out_reg  <= c_reg;
                z_out_reg  <= z_reg;
            end
        end
    end

    assign SEL_A   = rs1_reg;
    assign SEL_B   = rs2_reg;
    assign SEL_W   = rd_reg;
    assign DATA_IN = res_reg;
    assign done    = done_reg;
    assign RESULT  = result_reg;
    assign C       = c_out_reg;
    assign Z       = z_out_reg;

endmodule

// File: tb/tb_rf_sequencer.sv
// Testbench for rf_sequencer connected to a reg_file: directed scenarios plus
// random instructions, checked against an arithmetic reference model.
module tb_rf_sequencer;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         instr_valid;
    logic         instr_ready;
    logic [2:0]   op_in;
    logic [1:0]   rd_in, rs1_in, rs2_in;
    logic [W-1:0] imm_in;
    logic [1:0]   sel_a, sel_b, sel_w;
    logic [W-1:0] out_a, out_b, data_in, result;
    logic         write_en, done, c_flag, z_flag;

    int checks   = 0;
    int failures = 0;

    int cyc      = 0;
    int n_writes = 0;
    int n_dones  = 0;
    int acc_cycles[$];

    int exp_acc    = 0;
    int exp_writes = 0;
    int exp_dones  = 0;

    int model_rf [4];

    rf_sequencer #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .OP          (op_in),
        .RD          (rd_in),
        .RS1         (rs1_in),
        .RS2         (rs2_in),
        .IMM         (imm_in),
        .SEL_A       (sel_a),
        .SEL_B       (sel_b),
        .OUT_A       (out_a),
        .OUT_B       (out_b),
        .SEL_W       (sel_w),
        .DATA_IN     (data_in),
        .write_en    (write_en),
        .done        (done),
        .RESULT      (result),
        .C           (c_flag),
        .Z           (z_flag)
    );

    reg_file #(.DATA_W(W)) u_rf (
        .clk      (clk),
        .SEL_A    (sel_a),
        .SEL_B    (sel_b),
        .SEL_W    (sel_w),
        .DATA_IN  (data_in),
        .write_en (write_en),
        .OUT_A    (out_a),
        .OUT_B    (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle-level monitor: acceptances, writes and done pulses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (instr_valid && instr_ready) acc_cycles.push_back(cyc);
            if (write_en) n_writes <= n_writes + 1;
            if (done)     n_dones  <= n_dones + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference semantics computed straight from the opcode definitions.
    function automatic void ref_exec(input int op, input int a, input int b, input int imm,
                                     output int res, output int c, output int z);
        int s;
        c = 0;
        case (op)
            0: begin s = a + b; res = s % MOD; c = (s >= MOD) ? 1 : 0; end
            1: begin res = (a - b + MOD) % MOD; c = (a >= b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = a;
            6: res = imm;
            default: res = 0;
        endcase
        z = (res == 0) ? 1 : 0;
    endfunction

    task automatic drive_noise();
        instr_valid = 1'($urandom_range(0, 1));
        op_in  = 3'($urandom);
        rd_in  = 2'($urandom);
        rs1_in = 2'($urandom);
        rs2_in = 2'($urandom);
        imm_in = W'($urandom);
    endtask

    // Issue one instruction and check every step of its four-cycle life.
    // b2b leaves the bench in the done cycle so the next call is accepted there.
    task automatic exec_instr(input int op, input int rd, input int rs1, input int rs2,
                              input int imm, input bit b2b, input bit noise);
        int n, acc0, res, c, z;
        op_in = 3'(op); rd_in = 2'(rd); rs1_in = 2'(rs1); rs2_in = 2'(rs2); imm_in = W'(imm);
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin tick(); n++; end
        check("ready_wait", 32'(n < 20), 1);
        ref_exec(op, model_rf[rs1], model_rf[rs2], imm, res, c, z);
        acc0 = acc_cycles.size();
        tick();                                   // edge N: accepted
        exp_acc++;
        check("accept_once", acc_cycles.size() - acc0, 1);
        check("busy_ready", instr_ready, 0);
        check("done_low_read", done, 0);
        check("sel_a", sel_a, rs1);
        check("sel_b", sel_b, rs2);
        if (noise) drive_noise(); else instr_valid = 1'b0;
        tick();                                   // EXEC
        check("we_exec", write_en, 0);
        if (noise) drive_noise();
        tick();                                   // WB
        check("we_wb", write_en, (op != 7) ? 1 : 0);
        check("sel_w", sel_w, rd);
        check("data_in", data_in, res);
        if (noise) drive_noise();
        tick();                                   // edge N+3 wrote; done cycle
        instr_valid = 1'b0;
        if (op != 7) begin model_rf[rd] = res; exp_writes++; end
        exp_dones++;
        check("done", done, 1);
        check("result", result, res);
        check("c", c_flag, c);
        check("z", z_flag, z);
        check("ready_done", instr_ready, 1);
        check("rf_value", u_rf.mem[rd], model_rf[rd]);
        check("no_extra_acc", acc_cycles.size() - acc0, 1);
        $display("instr op=%0d rd=%0d rs1=%0d rs2=%0d imm=%0h -> result=%0h c=%0d z=%0d",
                 op, rd, rs1, rs2, imm, result, c_flag, z_flag);
        if (!b2b) begin
            tick();
            check("done_pulse", done, 0);
            check("result_held", result, res);
        end
    endtask

    int base, k, n, old_r1;
    int p_op [3] = '{6, 6, 0};
    int p_rd [3] = '{0, 1, 2};
    int p_rs2[3] = '{0, 0, 1};
    int p_imm[3] = '{1, 2, 0};

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0;
        op_in = '0; rd_in = '0; rs1_in = '0; rs2_in = '0; imm_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", write_en, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_c", c_flag, 0);
        check("rst_z", z_flag, 0);
        check("rst_sel_w", sel_w, 0);
        check("rst_data_in", data_in, 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", instr_ready, 1);

        // LDI R0,5 ; LDI R1,3 ; ADD R2,R0,R1 -> 8
        exec_instr(6, 0, 0, 0, 5, 0, 0);
        exec_instr(6, 1, 0, 0, 3, 0, 0);
        exec_instr(0, 2, 0, 1, 0, 0, 0);
        check("add_8", result, 8);
        check("add_8_rf", u_rf.mem[2], 8);
        exec_instr(6, 3, 0, 0, 0, 0, 0);

        // Carry and borrow corners
        exec_instr(6, 0, 0, 0, 9, 0, 0);
        exec_instr(6, 1, 0, 0, 9, 0, 0);
        exec_instr(0, 3, 0, 1, 0, 0, 0);
        check("add_wrap", result, 2);
        check("add_carry", c_flag, 1);
        exec_instr(1, 3, 0, 1, 0, 0, 0);
        check("sub_zero", result, 0);
        check("sub_zero_z", z_flag, 1);
        check("sub_zero_c", c_flag, 1);
        exec_instr(6, 0, 0, 0, 3, 0, 0);
        exec_instr(1, 3, 0, 1, 0, 0, 0);
        check("sub_borrow", result, 4'hA);
        check("sub_borrow_c", c_flag, 0);

        // NOP with RD=2 leaves R2 alone, busy-time noise on the inputs
        exec_instr(7, 2, 1, 3, 5, 0, 1);
        check("nop_r2", u_rf.mem[2], 8);
        check("nop_z", z_flag, 1);

        // Three queued instructions with instr_valid held high
        base = acc_cycles.size();
        k = 0; n = 0;
        op_in = 3'(p_op[0]); rd_in = 2'(p_rd[0]); rs1_in = 2'd0; rs2_in = 2'(p_rs2[0]); imm_in = W'(p_imm[0]);
        instr_valid = 1'b1;
        while (k < 3 && n < 40) begin
            tick(); n++;
            if (acc_cycles.size() - base > k) begin
                k++;
                if (k < 3) begin
                    op_in = 3'(p_op[k]); rd_in = 2'(p_rd[k]); rs2_in = 2'(p_rs2[k]); imm_in = W'(p_imm[k]);
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        repeat (5) tick();
        check("queue_count", acc_cycles.size() - base, 3);
        if (acc_cycles.size() - base >= 3) begin
            check("queue_gap1", acc_cycles[base+1] - acc_cycles[base], 4);
            check("queue_gap2", acc_cycles[base+2] - acc_cycles[base+1], 4);
        end
        model_rf[0] = 1; model_rf[1] = 2; model_rf[2] = 3;
        exp_acc += 3; exp_writes += 3; exp_dones += 3;
        check("queue_rf2", u_rf.mem[2], 3);
        check("queue_result", result, 3);
        $display("queue accepted=%0d r2=%0h", acc_cycles.size() - base, u_rf.mem[2]);

        // LDI R0,6 then MOV R1,R0 accepted in the done cycle
        exec_instr(6, 0, 0, 0, 6, 1, 0);
        exec_instr(5, 1, 0, 0, 0, 0, 0);
        check("mov_fwd", u_rf.mem[1], 6);

        // Reset during WB of LDI R1,7
        old_r1 = model_rf[1];
        op_in = 3'd6; rd_in = 2'd1; rs1_in = 2'd0; rs2_in = 2'd0; imm_in = W'(7);
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin tick(); n++; end
        tick(); instr_valid = 1'b0; exp_acc++;
        tick(); tick();
        check("abort_we_wb", write_en, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_we", write_en, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_sel_a", sel_a, 0);
        check("abort_data_in", data_in, 0);
        tick(); tick();
        check("abort_r1", u_rf.mem[1], old_r1);
        rst_n = 1'b1;
        tick();
        check("abort_ready", instr_ready, 1);
        check("abort_no_done", done, 0);
        $display("reset-abort r1=%0h ready=%0d", u_rf.mem[1], instr_ready);

        // Random instructions, occasional back-to-back, noise while busy
        for (int i = 0; i < 30; i++) begin
            exec_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, MOD - 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
        end
        repeat (3) tick();

        for (int r = 0; r < 4; r++) check("final_rf", u_rf.mem[r], model_rf[r]);
        check("total_acc", acc_cycles.size(), exp_acc);
        check("total_writes", n_writes, exp_writes);
        check("total_dones", n_dones, exp_dones);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_sequencer.md
RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 Parameter: DATA_W, default 4, register data width; SHALL equal the reg_file data width.
REQ-002 Clocking SHALL be one clock, clk; reset SHALL be rst_n, asynchronous, active-low.
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr_ready  output  1  instruction accepted when instr_valid and instr_ready are both high at a rising edge.
REQ-007 OP  input  3  opcode; 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV, 110 LDI, 111 NOP.
REQ-008 RD / RS1 / RS2  input  2 each  destination and source register indices.
REQ-009 IMM  input  DATA_W  immediate for LDI.
REQ-010 SEL_A / SEL_B  output  2 each  reg_file read selects.
REQ-011 OUT_A / OUT_B  input  DATA_W each  reg_file combinational read data.
REQ-012 SEL_W  output  2  reg_file write select.
REQ-013 DATA_IN  output  DATA_W  reg_file write data.
REQ-014 write_en  output  1  reg_file write enable; reg_file writes on the rising edge.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 RESULT  output  DATA_W  result of the completed instruction; C and Z, output 1 each, are its carry and zero flags.

Function
REQ-017 FSM states SHALL be IDLE, READ, EXEC and WB; instr_ready SHALL be 1 only in IDLE.
REQ-018 Acceptance in IDLE SHALL register OP, RD, RS1, RS2 and IMM, and the FSM SHALL go to READ.
REQ-019 READ SHALL drive SEL_A and SEL_B from the registered RS1 and RS2, capture OUT_A and OUT_B into operand registers at the edge, then go to EXEC.
REQ-020 EXEC SHALL compute through alu4, register the result, C and Z, then go to WB.
REQ-021 WB SHALL drive SEL_W from the registered RD and DATA_IN from the result register.
REQ-022 In WB, write_en SHALL be 1 for exactly one cycle, except for NOP; the FSM SHALL then return to IDLE.
REQ-023 done SHALL be a registered 1-cycle pulse in the cycle after WB, while already in IDLE; RESULT, C and Z SHALL be valid with done and held until the next done.
REQ-024 Latency: accept at edge N; reg_file write at edge N+3; done high in cycle N+4; throughput SHALL be one instruction per 4 cycles.
REQ-025 An instruction accepted in the done cycle SHALL read the value written at edge N+3, with no hazard logic.
REQ-026 ADD: A+B modulo 2^DATA_W; C SHALL be the carry-out.
REQ-027 SUB: A-B modulo 2^DATA_W; C SHALL be 1 when A>=B unsigned (no borrow).
REQ-028 AND, OR, XOR, MOV (result = A) and LDI (result = IMM) SHALL force C to 0.
REQ-029 NOP SHALL produce RESULT 0, C 0 and Z 1, and SHALL cause no write.
REQ-030 For all opcodes, Z SHALL be 1 when RESULT == 0.
REQ-031 RD equal to RS1 or RS2 SHALL be legal: operands are already captured before the write.
REQ-032 instr_valid while busy SHALL be ignored; the instruction fields SHALL NOT alter registered state.
REQ-033 write_en SHALL be 0 outside WB.
REQ-034 SEL_A, SEL_B, SEL_W and DATA_IN SHALL reflect their registered values in every state.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, write_en 0 and done 0.
REQ-036 rst_n low SHALL immediately force RESULT 0, C 0, Z 0, all select outputs 0, DATA_IN 0 and operand registers 0.
REQ-037 Reset during READ, EXEC or WB SHALL abort the instruction with no reg_file write and no done.
REQ-038 instr_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-039 Shared package rf_seq_pkg SHALL hold the opcode constants, the FSM state encoding and the default DATA_W.
REQ-040 Combinational sub-module alu4 SHALL take OP, A, B and IMM and return result, C and Z; rf_sequencer SHALL contain the FSM and registers only.
REQ-041 The bench SHALL connect rf_sequencer to a real reg_file instance.

Verification
REQ-042 LDI R0,5 then LDI R1,3, then ADD R2,R0,R1 -> write to R2 of 8; done with RESULT 8, C 0, Z 0; write at edge N+3, done in cycle N+4.
REQ-043 R0=9, R1=9: ADD R3,R0,R1 -> RESULT 2, C 1; SUB R3,R0,R1 -> RESULT 0, C 1, Z 1; R0=3, R1=9: SUB R3,R0,R1 -> RESULT A(hex), C 0.
REQ-044 NOP with RD=2 -> write_en never high, R2 unchanged, done with RESULT 0, Z 1.
REQ-045 instr_valid held high continuously with 3 queued instructions -> exactly 3 acceptances spaced 4 cycles; pulsing instr_valid while busy -> no extra acceptance.
REQ-046 rst_n low in WB of LDI R1,7 -> write_en drops immediately, R1 keeps its old value, no done, instr_ready 1 after release.
REQ-047 Back-to-back LDI R0,6 then MOV R1,R0, accepted in the done cycle -> R1 = 6.
